// File: rtl/readout_fsm_param.sv
// readout_fsm_param: clear/record/readout sequencer for the SPAD/LED imager; pushes {addr,phase,data} words to the host FIFO.
// Optional MASK_SKIP_EN: pixels whose pix_off bit is set are skipped in one cycle instead of being read and written.
module readout_fsm_param #(
  parameter int ADDR_W  = 9,
  parameter int PHASE_W = 1,
  parameter int DATA_W  = 6,
  parameter int OUT_W   = 16,
  parameter int WAIT_W  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                continuous,
  input  logic [31:0]                         shutter_periods,
  input  logic [WAIT_W-1:0]                   data_wait_cycles,
  input  logic [ADDR_W-1:0]                   last_addr,
  input  logic                                window_tick,
  input  logic                                pll_locked,
  input  logic [(1<<(ADDR_W+PHASE_W))-1:0]    pix_off_mask,
  input  logic [(1<<(ADDR_W+PHASE_W))-1:0]    dis_led_mask,
  input  logic [DATA_W-1:0]                   DIN,
  input  logic                                fifo_full,
  output logic [ADDR_W-1:0]                   ADDR,
  output logic [PHASE_W-1:0]                  PHASE,
  output logic                                pix_off,
  output logic                                dis_led,
  output logic                                MEM_CLEAR,
  output logic                                READ_EN,
  output logic                                SPAD_ON_CLK_EN,
  output logic                                LED_ON_CLK_EN,
  output logic                                LOAD,
  output logic [OUT_W-1:0]                    dout,
  output logic                                req_fifowr,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         frame_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RECORD = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_PUSH   = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [PHASE_W-1:0] phase_nxt;
  logic [31:0]        sh_shutter, win_cnt;
  logic [WAIT_W-1:0]  sh_wait, wait_cnt;
  logic [ADDR_W-1:0]  sh_last;
  logic               relatch, capture, wr_nxt, done_nxt, adv, skip, fresh, load_mask;
  logic               illegal;

  assign pix_off = pix_off_mask[{ADDR, PHASE}];
  assign dis_led = dis_led_mask[{ADDR, PHASE}];
  assign illegal = (state > S_PUSH);

`ifdef MASK_SKIP_EN
  assign skip      = (state == S_READ) && (wait_cnt == '0) && pix_off;
  assign load_mask = pix_off_mask[{addr_nxt, phase_nxt}];
`else
  assign skip      = 1'b0;
  assign load_mask = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = ADDR;
    phase_nxt = PHASE;
    relatch   = 1'b0;
    capture   = 1'b0;
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
    adv       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          relatch   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        addr_nxt  = '0;
        state_nxt = en ? S_RECORD : S_IDLE;
      end
      S_RECORD: begin
        if (win_cnt >= sh_shutter) state_nxt = S_READ;
      end
      S_READ: begin
        if (skip) begin
          adv = 1'b1;
        end else if (wait_cnt == sh_wait) begin
          capture   = 1'b1;
          state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!fifo_full) begin
          wr_nxt = 1'b1;
          adv    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Shared by the normal write path and the masked-skip path.
    if (adv) begin
      if (ADDR < sh_last) begin
        addr_nxt  = ADDR + 1'b1;
        state_nxt = S_READ;
      end else if (PHASE != {PHASE_W{1'b1}}) begin
        phase_nxt = PHASE + 1'b1;
        addr_nxt  = '0;
        state_nxt = S_CLEAR;
      end else begin
        phase_nxt = '0;
        addr_nxt  = '0;
        done_nxt  = 1'b1;
        if (en && continuous) begin
          relatch   = 1'b1;
          state_nxt = S_CLEAR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    end

    if (state_nxt == S_IDLE) begin
      addr_nxt  = '0;
      phase_nxt = '0;
    end
  end

  assign fresh = !((state == S_READ) && (state_nxt == S_READ) && !adv);

  always_ff @(posedge clk) begin
    if (rst || illegal) begin
      state          <= S_IDLE;
      ADDR           <= '0;
      PHASE          <= '0;
      sh_shutter     <= '0;
      sh_wait        <= '0;
      sh_last        <= '0;
      win_cnt        <= '0;
      wait_cnt       <= '0;
      dout           <= '0;
      req_fifowr     <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      busy           <= 1'b0;
      MEM_CLEAR      <= 1'b0;
      READ_EN        <= 1'b0;
      SPAD_ON_CLK_EN <= 1'b0;
      LED_ON_CLK_EN  <= 1'b0;
      LOAD           <= 1'b0;
    end else begin
      state <= state_nxt;
      ADDR  <= addr_nxt;
      PHASE <= phase_nxt;
      if (relatch) begin
        sh_shutter <= shutter_periods;
        sh_wait    <= data_wait_cycles;
        sh_last    <= last_addr;
      end
      if (state == S_CLEAR)
        win_cnt <= '0;
      else if (state == S_RECORD && window_tick && pll_locked)
        win_cnt <= win_cnt + 32'd1;
      wait_cnt <= fresh ? '0 : wait_cnt + 1'b1;
      if (capture) dout <= OUT_W'({ADDR, PHASE, DIN});
      req_fifowr <= wr_nxt;
      frame_done <= done_nxt;
      if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
      // Control outputs are registered from the next state so they line up with it.
      busy           <= (state_nxt != S_IDLE);
      MEM_CLEAR      <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
      READ_EN        <= (state_nxt == S_IDLE) || (state_nxt == S_READ) || (state_nxt == S_PUSH);
      SPAD_ON_CLK_EN <= (state_nxt == S_RECORD);
      LED_ON_CLK_EN  <= (state_nxt == S_RECORD);
      LOAD           <= (state_nxt == S_READ) && !(load_mask && fresh);
    end
  end

endmodule
